vc_weighted_arbiter: RTL and testbench

- Sits between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) in the transmission full-logic path.
- Each cycle it selects at most one VC head word, pops it, and pushes it one cycle later into D0 or D1, chosen by a destination bit in the word.
- Uses weighted priority: VC0 gets WEIGHT consecutive grants, then VC1 gets one. Honours almost-full backpressure from D0 and D1.

---
 rtl/vc_weighted_arbiter_if.sv | 27 ++
 rtl/vc_weighted_arbiter.sv | 105 ++++++++++
 tb/tb_vc_weighted_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_weighted_arbiter_if.sv
// Bus between the VC FIFOs, the arbiter and the destination FIFOs.
// master = arbiter side, slave = FIFO / environment side.
interface vc_weighted_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_almost_full;
  logic                  d1_almost_full;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );
endinterface

// File: rtl/vc_weighted_arbiter.sv
// Weighted VC0/VC1 arbiter feeding destination FIFOs D0/D1 (WEIGHT VC0 grants per VC1 grant).
// Optional grant counters are compiled in when ARB_STATS_EN is defined.
module vc_weighted_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  vc_weighted_arbiter_if.master bus,
  output logic                  active_out,
  output logic                  idle_out
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]            vc0_grant_cnt,
  output logic [7:0]            vc1_grant_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] WEIGHT_L = 4'(WEIGHT);

  state_t                state;
  state_t                state_next;
  logic [3:0]            wcnt;
  logic                  elig0;
  logic                  elig1;
  logic                  grant0;
  logic                  grant1;
  logic [DATA_WIDTH-1:0] grant_word;

  // Both IDLE->RUN and RUN->IDLE are decided by enable alone.
  assign state_next = enable ? RUN : IDLE;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    elig0  = 1'b0;
    elig1  = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && state == RUN) begin
      elig0 = !bus.vc0_empty &&
              !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
      elig1 = !bus.vc1_empty &&
              !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
      if (elig0 && elig1) begin
        grant0 = (wcnt < WEIGHT_L);
        grant1 = !grant0;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign bus.vc0_pop = grant0;
  assign bus.vc1_pop = grant1;
  assign grant_word  = grant1 ? bus.vc1_data : bus.vc0_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      bus.data_out <= '0;
      bus.d0_push  <= 1'b0;
      bus.d1_push  <= 1'b0;
      active_out   <= 1'b0;
      idle_out     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      active_out <= (state_next == RUN);
      idle_out   <= (state == RUN) && bus.vc0_empty && bus.vc1_empty &&
                    !(bus.d0_push || bus.d1_push);
      bus.d0_push <= (grant0 || grant1) && !grant_word[DEST_BIT];
      bus.d1_push <= (grant0 || grant1) &&  grant_word[DEST_BIT];
      if (grant0 || grant1) begin
        bus.data_out <= grant_word;
      end
      if (grant0) begin
        wcnt <= (wcnt >= WEIGHT_L) ? WEIGHT_L : wcnt + 4'd1;
      end else if (grant1) begin
        wcnt <= '0;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc0_grant_cnt <= '0;
      vc1_grant_cnt <= '0;
    end else if (state == IDLE && state_next == RUN) begin
      vc0_grant_cnt <= '0;
      vc1_grant_cnt <= '0;
    end else begin
      if (grant0 && vc0_grant_cnt != 8'hFF) vc0_grant_cnt <= vc0_grant_cnt + 8'd1;
      if (grant1 && vc1_grant_cnt != 8'hFF) vc1_grant_cnt <= vc1_grant_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_weighted_arbiter.sv
// Self-checking bench for vc_weighted_arbiter: hand sequences, a vector table and random
// traffic against a queue-based reference model (grant counters checked under ARB_STATS_EN).
module tb_vc_weighted_arbiter;
  localparam int DW = 6;
  localparam int DB = 4;
  localparam int WT = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic active_out;
  logic idle_out;
`ifdef ARB_STATS_EN
  logic [7:0] vc0_grant_cnt;
  logic [7:0] vc1_grant_cnt;
`endif

  vc_weighted_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  vc_weighted_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .WEIGHT(WT)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus),
    .active_out   (active_out),
    .idle_out     (idle_out)
`ifdef ARB_STATS_EN
    ,
    .vc0_grant_cnt(vc0_grant_cnt),
    .vc1_grant_cnt(vc1_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as queues, plus what should be on the outputs.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m_run;
  bit            m_push0;
  bit            m_push1;
  bit            m_idle;
  logic [DW-1:0] m_data;
  int            m_streak;   // VC0 grants since the last VC1 grant
  int            m_cnt0;
  int            m_cnt1;
  int            dut_grant;  // -1 none, 0 VC0, 1 VC1, as seen on the DUT pops

  task automatic model_reset();
    m_run = 0; m_push0 = 0; m_push1 = 0; m_idle = 0;
    m_data = '0; m_streak = 0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic drive();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc1_empty = (q1.size() == 0);
    bus.vc0_data  = (q0.size() != 0) ? q0[0] : '0;
    bus.vc1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  function automatic bit blocked(input logic [DW-1:0] w);
    return w[DB] ? bus.d1_almost_full : bus.d0_almost_full;
  endfunction

  // One clock: drive heads, check pops, advance model, check registered outputs.
  task automatic cycle(input string tag);
    bit            el0, el1;
    int            g;
    logic [DW-1:0] w;
    drive();
    #1;
    el0 = (q0.size() != 0) && !blocked(q0[0]);
    el1 = (q1.size() != 0) && !blocked(q1[0]);
    g = -1;
    if (m_run) begin
      if (el0 && el1) g = (m_streak < WT) ? 0 : 1;
      else if (el0)   g = 0;
      else if (el1)   g = 1;
    end
    dut_grant = bus.vc0_pop ? 0 : (bus.vc1_pop ? 1 : -1);
    check({tag, " pops"}, {30'd0, bus.vc0_pop, bus.vc1_pop}, {30'd0, g == 0, g == 1});

    m_idle  = m_run && q0.size() == 0 && q1.size() == 0 && !(m_push0 || m_push1);
    m_push0 = 0;
    m_push1 = 0;
    if (g >= 0) begin
      w = (g == 0) ? q0.pop_front() : q1.pop_front();
      m_data  = w;
      m_push0 = !w[DB];
      m_push1 =  w[DB];
    end
    if (g == 0) begin
      m_streak++;
      if (m_cnt0 < 255) m_cnt0++;
    end else if (g == 1) begin
      m_streak = 0;
      if (m_cnt1 < 255) m_cnt1++;
    end
    if (!m_run && enable) begin
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
    m_run = enable;

    @(posedge clk);
    #1;
    check({tag, " push"}, {30'd0, bus.d0_push, bus.d1_push}, {30'd0, m_push0, m_push1});
    check({tag, " data_out"}, 32'(bus.data_out), 32'(m_data));
    check({tag, " active_out"}, 32'(active_out), 32'(m_run));
    check({tag, " idle_out"}, 32'(idle_out), 32'(m_idle));
`ifdef ARB_STATS_EN
    check({tag, " vc0_grant_cnt"}, 32'(vc0_grant_cnt), m_cnt0);
    check({tag, " vc1_grant_cnt"}, 32'(vc1_grant_cnt), m_cnt1);
`endif
  endtask

  typedef struct {
    bit            e0, e1;
    logic [DW-1:0] w0, w1;
    bit            af0, af1;
    int            exp_grant;
    bit            ep0, ep1;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  int   exp_ord[16];

  initial begin
    // Starts with wcnt=0 and data_out=0x0A.
    vecs[0] = '{0, 1, 6'h05, 6'h00, 0, 0,  0, 1, 0, 6'h05};
    vecs[1] = '{1, 1, 6'h00, 6'h00, 0, 0, -1, 0, 0, 6'h05};
    vecs[2] = '{0, 1, 6'h12, 6'h00, 0, 1, -1, 0, 0, 6'h05};
    vecs[3] = '{0, 0, 6'h12, 6'h03, 0, 1,  1, 1, 0, 6'h03};
    vecs[4] = '{0, 0, 6'h11, 6'h02, 1, 0,  0, 0, 1, 6'h11};
    vecs[5] = '{0, 0, 6'h01, 6'h13, 0, 0,  0, 1, 0, 6'h01};
    vecs[6] = '{0, 0, 6'h07, 6'h14, 0, 0,  0, 1, 0, 6'h07};
    vecs[7] = '{0, 0, 6'h08, 6'h15, 0, 0,  1, 0, 1, 6'h15};
    vecs[8] = '{0, 0, 6'h09, 6'h16, 1, 1, -1, 0, 0, 6'h15};
    vecs[9] = '{0, 0, 6'h3F, 6'h20, 0, 0,  0, 0, 1, 6'h3F};
    exp_ord = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1};

    // Reset with enable low and both VCs holding data.
    reset = 1'b0;
    enable = 1'b0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    q0 = '{6'h01, 6'h02};
    q1 = '{6'h03};
    model_reset();
    drive();
    #2;
    check("rst pops", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
    check("rst push", {30'd0, bus.d0_push, bus.d1_push}, 32'd0);
    check("rst data_out", 32'(bus.data_out), 32'd0);
    check("rst active/idle", {30'd0, active_out, idle_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle("idle_en0");
    q0.delete();
    q1.delete();
    enable = 1'b1;
    cycle("enable_rise");
    check("active_after_enable", 32'(active_out), 32'd1);
    cycle("run_empty1");
    cycle("run_empty2");
    check("idle_when_empty", 32'(idle_out), 32'd1);

    // Weighted order, everything to D0.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(8 + i));
    end
    for (int i = 0; i < 16; i++) begin
      cycle("weight");
      check($sformatf("weight order %0d", i), 32'(dut_grant), 32'(exp_ord[i]));
    end

    // Blocked VC0 head does not stall VC1.
    q0 = '{6'b010110};
    q1 = '{6'b000101};
    bus.d1_almost_full = 1'b1;
    cycle("bp1");
    check("bp vc1 granted", 32'(dut_grant), 32'd1);
    check("bp d0_push", {30'd0, bus.d0_push, bus.d1_push}, 32'd2);
    cycle("bp2");
    check("bp vc0 stalled", 32'(dut_grant), -32'sd1);
    bus.d1_almost_full = 1'b0;
    cycle("bp3");
    check("bp release d1_push", {30'd0, bus.d0_push, bus.d1_push}, 32'd1);
    check("bp release data", 32'(bus.data_out), 32'(6'b010110));

    // VC0 alone six times, then VC1 wins immediately.
    for (int i = 0; i < 6; i++) q0.push_back(6'(32 + i));
    for (int i = 0; i < 6; i++) begin
      cycle("solo");
      check($sformatf("solo vc0 %0d", i), 32'(dut_grant), 32'd0);
    end
    q0.push_back(6'h0C);
    q1.push_back(6'h0D);
    cycle("sat");
    check("saturated wcnt -> vc1", 32'(dut_grant), 32'd1);
    cycle("sat_drain");

    // Vector table, starting from wcnt=0 after a VC1 grant.
    q1 = '{6'h0A};
    cycle("vec_pre");
    foreach (vecs[i]) begin
      q0.delete();
      q1.delete();
      if (!vecs[i].e0) q0.push_back(vecs[i].w0);
      if (!vecs[i].e1) q1.push_back(vecs[i].w1);
      bus.d0_almost_full = vecs[i].af0;
      bus.d1_almost_full = vecs[i].af1;
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d grant", i), 32'(dut_grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d push", i), {30'd0, bus.d0_push, bus.d1_push},
            {30'd0, vecs[i].ep0, vecs[i].ep1});
      check($sformatf("vec%0d data", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
    end
    q0.delete();
    q1.delete();
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;

    // enable falls in the same cycle as a VC0 pop.
    q0 = '{6'h04, 6'h05, 6'h06};
    enable = 1'b0;
    cycle("en_drop");
    check("en_drop popped", 32'(dut_grant), 32'd0);
    check("en_drop push completes", {30'd0, bus.d0_push, bus.d1_push}, 32'd2);
    check("en_drop data", 32'(bus.data_out), 32'h04);
    check("en_drop active falls", 32'(active_out), 32'd0);
    cycle("en_off");
    check("en_off no pop", 32'(dut_grant), -32'sd1);

    // Reset while a push is pending.
    enable = 1'b1;
    cycle("re_enable");
    cycle("pre_reset_pop");
    check("push pending before reset", 32'(bus.d0_push), 32'd1);
    reset = 1'b0;
    #1;
    check("reset clears push", {30'd0, bus.d0_push, bus.d1_push}, 32'd0);
    check("reset clears data", 32'(bus.data_out), 32'd0);
    check("reset pops", {30'd0, bus.vc0_pop, bus.vc1_pop}, 32'd0);
    check("reset active", 32'(active_out), 32'd0);
    model_reset();
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle("post_reset_rise");

`ifdef ARB_STATS_EN
    for (int i = 0; i < 5; i++) q0.push_back(6'(i));
    for (int i = 0; i < 2; i++) q1.push_back(6'(8 + i));
    for (int i = 0; i < 8; i++) cycle("stats");
    check("stats vc0 = 5", 32'(vc0_grant_cnt), 32'd5);
    check("stats vc1 = 2", 32'(vc1_grant_cnt), 32'd2);
    enable = 1'b0;
    cycle("stats_off");
    enable = 1'b1;
    cycle("stats_rerun");
    check("stats vc0 cleared", 32'(vc0_grant_cnt), 32'd0);
    check("stats vc1 cleared", 32'(vc1_grant_cnt), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      bus.d0_almost_full = ($urandom_range(0, 3) == 0);
      bus.d1_almost_full = ($urandom_range(0, 3) == 0);
      if (q0.size() < 4 && $urandom_range(0, 1) == 1) q0.push_back(6'($urandom));
      if (q1.size() < 4 && $urandom_range(0, 2) == 0) q1.push_back(6'($urandom));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
